// File: rtl/axis_py_lockin_sweep_ctrl.sv
// Frequency-sweep sequencer for the RPSPMC lock-in: programs each point over the config bus,
// waits a settle time in decimation ticks, captures A2/X/Y and emits one AXIS result beat per point.
//
//   state   | meaning
//   IDLE    | waiting for an accepted start
//   LOAD    | one-cycle config write to the lock-in for the current point
//   HOLD    | HOLD_CYCLES wait while the lock-in reinitialises
//   SETTLE  | counting deci_clk rising edges
//   CAPTURE | latch A2/X/Y on the next deci_clk rising edge
//   EMIT    | result beat valid, held until accepted
//   NEXT    | advance to the next point or finish
module axis_py_lockin_sweep_ctrl #(
  parameter int CONFIGURATION_ADDRESS = 1001,
  parameter int LCK_ADDRESS           = 999,
  parameter int AM2_DATA_WIDTH        = 48,
  parameter int LCK_CORRSUM_WIDTH     = 32,
  parameter int HOLD_CYCLES           = 8
) (
  input  logic                                                a_clk,
  input  logic                                                a_rst,
  input  logic [31:0]                                         config_addr,
  input  logic [511:0]                                        config_data,
  output logic [31:0]                                         lck_config_addr,
  output logic [511:0]                                        lck_config_data,
  input  logic                                                deci_clk,
  input  logic [AM2_DATA_WIDTH-1:0]                           S_AXIS_A2_tdata,
  input  logic                                                S_AXIS_A2_tvalid,
  input  logic [LCK_CORRSUM_WIDTH-1:0]                        S_AXIS_X_tdata,
  input  logic                                                S_AXIS_X_tvalid,
  input  logic [LCK_CORRSUM_WIDTH-1:0]                        S_AXIS_Y_tdata,
  input  logic                                                S_AXIS_Y_tvalid,
  output logic [AM2_DATA_WIDTH+2*LCK_CORRSUM_WIDTH+16-1:0]    M_AXIS_RESULT_tdata,
  output logic                                                M_AXIS_RESULT_tvalid,
  input  logic                                                M_AXIS_RESULT_tready,
  output logic                                                busy,
  output logic                                                done
);

  localparam int RES_W = AM2_DATA_WIDTH + 2*LCK_CORRSUM_WIDTH + 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HOLD, S_SETTLE, S_CAPTURE, S_EMIT, S_NEXT
  } state_t;

  state_t r_state, w_state_next;

  logic [1:0]       r_mode;
  logic [31:0]      r_gain;
  logic [15:0]      r_n2;
  logic [47:0]      r_phase;
  logic [47:0]      r_step;
  logic [15:0]      r_npoints;
  logic [15:0]      r_settle;
  logic [15:0]      r_index;
  logic [15:0]      r_cnt;
  logic             r_deci_q;
  logic             r_done;
  logic [31:0]      r_lck_addr;
  logic [511:0]     r_lck_data;
  logic [RES_W-1:0] r_result;

  logic         w_cfg_hit, w_abort, w_accept, w_edge, w_last;
  logic [1:0]   w_pt_mode;
  logic [31:0]  w_pt_gain;
  logic [15:0]  w_pt_n2;
  logic [47:0]  w_pt_phase;
  logic [511:0] w_lck_word;
  logic         w_unused;

  assign w_cfg_hit = (config_addr == 32'(CONFIGURATION_ADDRESS));
  assign w_abort   = w_cfg_hit & config_data[1];
  assign w_accept  = (r_state == S_IDLE) & w_cfg_hit & config_data[0] & ~config_data[1]
                   & (config_data[207:192] != 16'd0);
  assign w_edge    = deci_clk & ~r_deci_q;
  assign w_last    = (r_index == r_npoints - 16'd1);
  assign w_unused  = ^{config_data[511:224], config_data[191:176], config_data[31:4],
                       S_AXIS_A2_tvalid, S_AXIS_X_tvalid, S_AXIS_Y_tvalid};

  // First point comes straight off the config bus so the write lands one cycle after start.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_pt_mode  = config_data[3:2];
      w_pt_gain  = config_data[63:32];
      w_pt_n2    = config_data[79:64];
      w_pt_phase = config_data[127:80];
    end else begin
      w_pt_mode  = r_mode;
      w_pt_gain  = r_gain;
      w_pt_n2    = r_n2;
      w_pt_phase = r_phase + r_step;
    end
    w_lck_word          = '0;
    w_lck_word[1:0]     = w_pt_mode;
    w_lck_word[63:32]   = w_pt_gain;
    w_lck_word[79:64]   = w_pt_n2;
    w_lck_word[127:80]  = w_pt_phase;
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = S_LOAD;
      S_LOAD:    w_state_next = S_HOLD;
      S_HOLD:    if (r_cnt == 16'd0) w_state_next = (r_settle == 16'd0) ? S_CAPTURE : S_SETTLE;
      S_SETTLE:  if (w_edge && r_cnt == 16'd1) w_state_next = S_CAPTURE;
      S_CAPTURE: if (w_edge) w_state_next = S_EMIT;
      S_EMIT:    if (M_AXIS_RESULT_tready) w_state_next = S_NEXT;
      S_NEXT:    w_state_next = w_last ? S_IDLE : S_LOAD;
      default:   w_state_next = S_IDLE;
    endcase
    if (w_abort) w_state_next = S_IDLE;
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_mode     <= '0;
      r_gain     <= '0;
      r_n2       <= '0;
      r_phase    <= '0;
      r_step     <= '0;
      r_npoints  <= '0;
      r_settle   <= '0;
      r_index    <= '0;
      r_cnt      <= '0;
      r_deci_q   <= 1'b0;
      r_done     <= 1'b0;
      r_lck_addr <= '0;
      r_lck_data <= '0;
      r_result   <= '0;
    end else begin
      r_deci_q <= deci_clk;
      r_done   <= (r_state == S_NEXT) & w_last & ~w_abort;

      if (w_accept) begin
        r_mode    <= config_data[3:2];
        r_gain    <= config_data[63:32];
        r_n2      <= config_data[79:64];
        r_step    <= config_data[175:128];
        r_npoints <= config_data[207:192];
        r_settle  <= config_data[223:208];
        r_index   <= '0;
      end

      if (w_state_next == S_LOAD) begin
        r_lck_addr <= 32'(LCK_ADDRESS);
        r_lck_data <= w_lck_word;
        r_phase    <= w_pt_phase;
      end else begin
        r_lck_addr <= '0;
      end

      if (r_state == S_NEXT && w_state_next == S_LOAD)
        r_index <= r_index + 16'd1;

      // One down-counter serves both the HOLD wait and the settle edge count.
      if (r_state == S_LOAD)
        r_cnt <= 16'(HOLD_CYCLES - 1);
      else if (r_state == S_HOLD)
        r_cnt <= (r_cnt == 16'd0) ? r_settle : r_cnt - 16'd1;
      else if (r_state == S_SETTLE && w_edge)
        r_cnt <= r_cnt - 16'd1;

      if (r_state == S_CAPTURE && w_edge)
        r_result <= {S_AXIS_A2_tdata, S_AXIS_X_tdata, S_AXIS_Y_tdata, r_index};
    end
  end

  always_comb begin
    busy                 = (r_state != S_IDLE);
    M_AXIS_RESULT_tvalid = (r_state == S_EMIT);
    M_AXIS_RESULT_tdata  = r_result;
    lck_config_addr      = r_lck_addr;
    lck_config_data      = r_lck_data;
    done                 = r_done;
  end

endmodule
